// File: rtl/alu_decoder_memory.sv
// rtl/alu_decoder_memory.sv - instruction memory, field decoder, ALU and registered NZCV flags
module alu_decoder_memory #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter int INST_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_we,
  input  logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [INST_SIZE-1:0] mem_wdata,
  output logic [INST_SIZE-1:0] inst,
  output logic [4:0]           opcode,
  output logic [2:0]           rx,
  output logic [2:0]           ry,
  output logic [7:0]           imm,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic                 exec,
  output logic [WORD_SIZE-1:0] alu_out,
  output logic [3:0]           flags,
  output logic                 reg_we,
  output logic [WORD_SIZE-1:0] reg_wdata,
  output logic                 jump_taken,
  output logic                 illegal
);

  localparam int MSB = WORD_SIZE - 1;

  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_ADC   = 5'b00010;
  localparam logic [4:0] OP_SUB   = 5'b00011;
  localparam logic [4:0] OP_AND   = 5'b00100;
  localparam logic [4:0] OP_OR    = 5'b00101;
  localparam logic [4:0] OP_XOR   = 5'b00110;
  localparam logic [4:0] OP_CMP   = 5'b00111;
  localparam logic [4:0] OP_MOV   = 5'b01000;
  localparam logic [4:0] OP_STR   = 5'b10000;
  localparam logic [4:0] OP_LOAD  = 5'b10001;
  localparam logic [4:0] OP_RSTR  = 5'b10010;
  localparam logic [4:0] OP_RLOAD = 5'b10011;
  localparam logic [4:0] OP_JMP   = 5'b10100;
  localparam logic [4:0] OP_JC    = 5'b10101;
  localparam logic [4:0] OP_JZ    = 5'b10110;
  localparam logic [4:0] OP_JN    = 5'b10111;
  localparam logic [4:0] OP_INC   = 5'b11000;
  localparam logic [4:0] OP_DEC   = 5'b11001;
  localparam logic [4:0] OP_SHR   = 5'b11010;
  localparam logic [4:0] OP_SHL   = 5'b11011;
  localparam logic [4:0] OP_SET   = 5'b11111;

  logic [INST_SIZE-1:0] mem [2**ADDR_SIZE];
  logic [WORD_SIZE:0]   wide;
  logic                 c_new;
  logic                 v_new;
  logic                 flag_op;

  // Memory content survives reset; only the write port is blocked while rst is low.
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign inst   = mem[mem_addr];
  assign opcode = inst[15:11];
  assign rx     = inst[10:8];
  assign ry     = inst[7:5];
  assign imm    = inst[7:0];

  always_comb begin
    wide       = '0;
    alu_out    = '0;
    c_new      = 1'b0;
    v_new      = 1'b0;
    flag_op    = 1'b0;
    reg_we     = 1'b0;
    reg_wdata  = '0;
    jump_taken = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        wide    = {1'b0, a} + {1'b0, b} + (WORD_SIZE+1)'((opcode == OP_ADC) & flags[1]);
        alu_out = wide[MSB:0];
        c_new   = wide[WORD_SIZE];
        v_new   = (a[MSB] == b[MSB]) && (alu_out[MSB] != a[MSB]);
        flag_op = 1'b1;
        reg_we  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        // Bit WORD_SIZE of the zero-extended difference is the borrow.
        wide    = {1'b0, a} - {1'b0, b};
        alu_out = wide[MSB:0];
        c_new   = wide[WORD_SIZE];
        v_new   = (a[MSB] != b[MSB]) && (alu_out[MSB] != a[MSB]);
        flag_op = 1'b1;
        reg_we  = (opcode == OP_SUB);
      end
      OP_AND: begin alu_out = a & b; flag_op = 1'b1; reg_we = 1'b1; end
      OP_OR:  begin alu_out = a | b; flag_op = 1'b1; reg_we = 1'b1; end
      OP_XOR: begin alu_out = a ^ b; flag_op = 1'b1; reg_we = 1'b1; end
      OP_MOV: begin alu_out = b; reg_we = 1'b1; end
      OP_INC: begin
        wide    = {1'b0, a} + (WORD_SIZE+1)'(1);
        alu_out = wide[MSB:0];
        c_new   = wide[WORD_SIZE];
        v_new   = ~a[MSB] & alu_out[MSB];
        flag_op = 1'b1;
        reg_we  = 1'b1;
      end
      OP_DEC: begin
        wide    = {1'b0, a} - (WORD_SIZE+1)'(1);
        alu_out = wide[MSB:0];
        c_new   = wide[WORD_SIZE];
        v_new   = a[MSB] & ~alu_out[MSB];
        flag_op = 1'b1;
        reg_we  = 1'b1;
      end
      OP_SHR: begin alu_out = a >> 1; c_new = a[0];   flag_op = 1'b1; reg_we = 1'b1; end
      OP_SHL: begin alu_out = a << 1; c_new = a[MSB]; flag_op = 1'b1; reg_we = 1'b1; end
      OP_STR, OP_LOAD, OP_RSTR, OP_RLOAD: ;
      OP_JMP: jump_taken = 1'b1;
      OP_JC:  jump_taken = flags[1];
      OP_JZ:  jump_taken = flags[2];
      OP_JN:  jump_taken = flags[3];
      OP_SET: reg_we = 1'b1;
      default: illegal = 1'b1;
    endcase
    reg_wdata = (opcode == OP_SET) ? WORD_SIZE'(imm) : alu_out;
  end

  // flags = {N, Z, C, V}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags <= 4'b0000;
    end else if (exec && flag_op) begin
      flags <= {alu_out[MSB], (alu_out == '0), c_new, v_new};
    end
  end

endmodule

// File: tb/tb_alu_decoder_memory.sv
// tb/tb_alu_decoder_memory.sv - directed self-checking bench for alu_decoder_memory
module tb_alu_decoder_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [7:0]  mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic [15:0] inst;
  logic [4:0]  opcode;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [7:0]  imm;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        exec = 1'b0;
  logic [7:0]  alu_out;
  logic [3:0]  flags;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic        jump_taken;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;

  alu_decoder_memory dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .inst(inst), .opcode(opcode), .rx(rx), .ry(ry), .imm(imm),
    .a(a), .b(b), .exec(exec), .alu_out(alu_out), .flags(flags),
    .reg_we(reg_we), .reg_wdata(reg_wdata), .jump_taken(jump_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [7:0] ad, input logic [15:0] d);
    exec = 1'b0;
    mem_we = 1'b1;
    mem_addr = ad;
    mem_wdata = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags_async: got %b want 0000", flags); end
    tick();
    tick();
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags_held: got %b want 0000", flags); end
    rst = 1'b1;
  endtask

  task automatic test_memory();
    write_mem(8'h00, 16'h0A21);
    mem_addr = 8'h00;
    #1;
    vectors++; if (inst !== 16'h0A21) begin miscompares++; $display("FAIL mem_inst: got %h want 0a21", inst); end
    vectors++; if (opcode !== 5'b00001) begin miscompares++; $display("FAIL dec_opcode: got %b want 00001", opcode); end
    vectors++; if (rx !== 3'd2) begin miscompares++; $display("FAIL dec_rx: got %0d want 2", rx); end
    vectors++; if (ry !== 3'd1) begin miscompares++; $display("FAIL dec_ry: got %0d want 1", ry); end
    vectors++; if (imm !== 8'h21) begin miscompares++; $display("FAIL dec_imm: got %h want 21", imm); end
    write_mem(8'h01, 16'h1234);
    mem_we = 1'b1;
    mem_addr = 8'h01;
    mem_wdata = 16'h5678;
    #1;
    vectors++; if (inst !== 16'h1234) begin miscompares++; $display("FAIL mem_old_before_edge: got %h want 1234", inst); end
    tick();
    mem_we = 1'b0;
    vectors++; if (inst !== 16'h5678) begin miscompares++; $display("FAIL mem_new_after_edge: got %h want 5678", inst); end
  endtask

  task automatic test_add_adc();
    write_mem(8'h03, 16'h1000);
    mem_addr = 8'h00; a = 8'hFF; b = 8'h01; exec = 1'b1;
    #1;
    vectors++; if (alu_out !== 8'h00) begin miscompares++; $display("FAIL add_out: got %h want 00", alu_out); end
    vectors++; if (reg_we !== 1'b1) begin miscompares++; $display("FAIL add_reg_we: got %b want 1", reg_we); end
    tick();
    vectors++; if (flags !== 4'b0110) begin miscompares++; $display("FAIL add_flags: got %b want 0110", flags); end
    mem_addr = 8'h03; a = 8'h10; b = 8'h20;
    #1;
    vectors++; if (alu_out !== 8'h31) begin miscompares++; $display("FAIL adc_out: got %h want 31", alu_out); end
    tick();
    exec = 1'b0;
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL adc_flags: got %b want 0000", flags); end
  endtask

  task automatic test_cmp_hold();
    write_mem(8'h04, 16'h3800);
    mem_addr = 8'h04; a = 8'h05; b = 8'h07; exec = 1'b1;
    #1;
    vectors++; if (alu_out !== 8'hFE) begin miscompares++; $display("FAIL cmp_out: got %h want fe", alu_out); end
    vectors++; if (reg_we !== 1'b0) begin miscompares++; $display("FAIL cmp_reg_we: got %b want 0", reg_we); end
    tick();
    vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL cmp_flags: got %b want 1010", flags); end
    mem_addr = 8'h00; a = 8'h00; b = 8'h00; exec = 1'b0;
    tick();
    vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL exec_low_hold: got %b want 1010", flags); end
  endtask

  task automatic test_alu_ops();
    logic [15:0] op_inst [5] = '{16'h1800, 16'hD000, 16'hD800, 16'hC000, 16'hC800};
    logic [7:0]  op_a    [5] = '{8'h80, 8'h81, 8'h40, 8'h7F, 8'h00};
    logic [7:0]  exp_out [5] = '{8'h7F, 8'h40, 8'h80, 8'h80, 8'hFF};
    logic [3:0]  exp_flg [5] = '{4'b0001, 4'b0010, 4'b1000, 4'b1001, 4'b1010};
    for (int i = 0; i < 5; i++) begin
      write_mem(8'h10 + 8'(i), op_inst[i]);
      mem_addr = 8'h10 + 8'(i); a = op_a[i]; b = 8'h01; exec = 1'b1;
      #1;
      vectors++; if (alu_out !== exp_out[i]) begin miscompares++; $display("FAIL alu_out[%0d]: got %h want %h", i, alu_out, exp_out[i]); end
      vectors++; if (reg_we !== 1'b1) begin miscompares++; $display("FAIL alu_reg_we[%0d]: got %b want 1", i, reg_we); end
      tick();
      exec = 1'b0;
      vectors++; if (flags !== exp_flg[i]) begin miscompares++; $display("FAIL alu_flags[%0d]: got %b want %b", i, flags, exp_flg[i]); end
    end
  endtask

  task automatic test_jumps_set_illegal();
    logic [15:0] j_inst [4] = '{16'hB000, 16'hB800, 16'hA800, 16'hA000};
    logic        j_exp  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      write_mem(8'h20 + 8'(i), j_inst[i]);
      mem_addr = 8'h20 + 8'(i);
      #1;
      vectors++; if (jump_taken !== j_exp[i]) begin miscompares++; $display("FAIL jump[%0d]: got %b want %b", i, jump_taken, j_exp[i]); end
      vectors++; if (reg_we !== 1'b0) begin miscompares++; $display("FAIL jump_reg_we[%0d]: got %b want 0", i, reg_we); end
    end
    write_mem(8'h30, 16'hF85A);
    mem_addr = 8'h30;
    #1;
    vectors++; if (reg_wdata !== 8'h5A) begin miscompares++; $display("FAIL set_wdata: got %h want 5a", reg_wdata); end
    vectors++; if (reg_we !== 1'b1) begin miscompares++; $display("FAIL set_reg_we: got %b want 1", reg_we); end
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL set_illegal: got %b want 0", illegal); end
    write_mem(8'h31, 16'h6000);
    mem_addr = 8'h31; a = 8'h00; b = 8'h00; exec = 1'b1;
    #1;
    vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_flag: got %b want 1", illegal); end
    vectors++; if (reg_we !== 1'b0) begin miscompares++; $display("FAIL illegal_reg_we: got %b want 0", reg_we); end
    vectors++; if (jump_taken !== 1'b0) begin miscompares++; $display("FAIL illegal_jump: got %b want 0", jump_taken); end
    tick();
    vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL illegal_flags_hold: got %b want 1010", flags); end
    write_mem(8'h32, 16'h4000);
    mem_addr = 8'h32; b = 8'h33; exec = 1'b1;
    #1;
    vectors++; if (reg_wdata !== 8'h33) begin miscompares++; $display("FAIL mov_wdata: got %h want 33", reg_wdata); end
    tick();
    exec = 1'b0;
    vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL mov_flags_hold: got %b want 1010", flags); end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b0;
    #1;
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL async_reset_flags: got %b want 0000", flags); end
    mem_we = 1'b1; mem_addr = 8'h00; mem_wdata = 16'hFFFF;
    tick();
    mem_we = 1'b0;
    vectors++; if (inst !== 16'h0A21) begin miscompares++; $display("FAIL mem_kept_in_reset: got %h want 0a21", inst); end
    vectors++; if (opcode !== 5'b00001) begin miscompares++; $display("FAIL dec_in_reset: got %b want 00001", opcode); end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_memory();
    test_add_adc();
    test_cmp_hold();
    test_alu_ops();
    test_cmp_hold();
    test_jumps_set_illegal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
